// File: rtl/ram_operand_sequencer.sv
// ram_operand_sequencer: initiator-side controller for the 8-entry dual-port
// operand RAM in front of the field-arithmetic unit.
//
// Operation: accepts one command (src_a, src_b, dst), reads both sources in
// parallel on RAM ports A and B, hands the operands to the arithmetic unit
// with a valid/ready handshake, and writes the returned result through port A.
//
// Ports:
//   clk, rst                      rising-edge clock, sync active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_src_a/cmd_src_b/cmd_dst   operand and result addresses
//   ram_a_w/adbus/wdata/rdata     RAM port A (reads sources, writes result)
//   ram_b_w/adbus/rdata           RAM port B (read only, ram_b_w tied 0)
//   op_valid/op_ready/op_a/op_b   operand handshake to arithmetic unit
//   res_valid/res_ready/res_data  result handshake from arithmetic unit
//   done                          one-cycle pulse with the RAM write
//   busy                          high whenever not IDLE
//
// Build option: RAM_SEQ_FWD_EN enables forwarding of the last written result
// to sources matching the last destination; when both sources forward, the
// RAM read is skipped and IDLE goes straight to ISSUE.
module ram_operand_sequencer #(
    parameter int DATA = 256,
    parameter int ADDR = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ADDR-1:0] cmd_src_a,
    input  logic [ADDR-1:0] cmd_src_b,
    input  logic [ADDR-1:0] cmd_dst,
    output logic            ram_a_w,
    output logic [ADDR-1:0] ram_a_adbus,
    output logic [DATA-1:0] ram_a_wdata,
    input  logic [DATA-1:0] ram_a_rdata,
    output logic            ram_b_w,
    output logic [ADDR-1:0] ram_b_adbus,
    input  logic [DATA-1:0] ram_b_rdata,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [DATA-1:0] op_a,
    output logic [DATA-1:0] op_b,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [DATA-1:0] res_data,
    output logic            done,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        ISSUE,
        WAIT,
        WRITE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ADDR-1:0] src_a_q;
    logic [ADDR-1:0] src_b_q;
    logic [ADDR-1:0] dst_q;
    logic [DATA-1:0] op_a_q;
    logic [DATA-1:0] op_b_q;
    logic [DATA-1:0] res_q;
    logic            accept;
    logic            hit_a;
    logic            hit_b;
    logic            fwd_a_q;
    logic            fwd_b_q;

    assign accept = (state_q == IDLE) && cmd_valid;

`ifdef RAM_SEQ_FWD_EN
    // res_q doubles as the last-result store: it only changes in WAIT,
    // so it still holds the previous result while the next command runs.
    logic [ADDR-1:0] last_dst_q;
    logic            last_vld_q;

    assign hit_a = last_vld_q && (cmd_src_a == last_dst_q);
    assign hit_b = last_vld_q && (cmd_src_b == last_dst_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dst_q <= '0;
            last_vld_q <= 1'b0;
            fwd_a_q    <= 1'b0;
            fwd_b_q    <= 1'b0;
        end else begin
            if (accept) begin
                fwd_a_q <= hit_a;
                fwd_b_q <= hit_b;
            end
            if (state_q == WRITE) begin
                last_dst_q <= dst_q;
                last_vld_q <= 1'b1;
            end
        end
    end
`else
    assign hit_a   = 1'b0;
    assign hit_b   = 1'b0;
    assign fwd_a_q = 1'b0;
    assign fwd_b_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (hit_a && hit_b) ? ISSUE : READ;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = ISSUE;
            ISSUE: begin
                if (op_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
                dst_q   <= cmd_dst;
                // Fully forwarded command skips CAPTURE, so load here.
                if (hit_a && hit_b) begin
                    op_a_q <= res_q;
                    op_b_q <= res_q;
                end
            end
            if (state_q == CAPTURE) begin
                op_a_q <= fwd_a_q ? res_q : ram_a_rdata;
                op_b_q <= fwd_b_q ? res_q : ram_b_rdata;
            end
            if ((state_q == WAIT) && res_valid) begin
                res_q <= res_data;
            end
        end
    end

    // cmd_ready is masked by rst so it reads 0 throughout the reset cycle.
    assign cmd_ready   = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign op_valid    = (state_q == ISSUE);
    assign res_ready   = (state_q == WAIT);
    assign ram_a_w     = (state_q == WRITE);
    assign done        = (state_q == WRITE);
    assign ram_b_w     = 1'b0;
    assign ram_a_wdata = res_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;

    always_comb begin
        ram_a_adbus = '0;
        ram_b_adbus = '0;
        if (state_q == READ) begin
            ram_a_adbus = src_a_q;
            ram_b_adbus = src_b_q;
        end else if (state_q == WRITE) begin
            ram_a_adbus = dst_q;
        end
    end

endmodule

// File: tb/tb_ram_operand_sequencer.sv
// tb_ram_operand_sequencer: directed bench for ram_operand_sequencer with a
// registered-read RAM model and a multiplying arithmetic-unit responder.
module tb_ram_operand_sequencer;

    localparam int DATA = 256;
    localparam int ADDR = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ADDR-1:0] cmd_src_a;
    logic [ADDR-1:0] cmd_src_b;
    logic [ADDR-1:0] cmd_dst;
    logic            ram_a_w;
    logic [ADDR-1:0] ram_a_adbus;
    logic [DATA-1:0] ram_a_wdata;
    logic [DATA-1:0] ram_a_rdata = '0;
    logic            ram_b_w;
    logic [ADDR-1:0] ram_b_adbus;
    logic [DATA-1:0] ram_b_rdata = '0;
    logic            op_valid;
    logic            op_ready;
    logic [DATA-1:0] op_a;
    logic [DATA-1:0] op_b;
    logic            res_valid;
    logic            res_ready;
    logic [DATA-1:0] res_data;
    logic            done;
    logic            busy;

    logic [DATA-1:0] mem [8] = '{
        256'd0, 256'd5, 256'd7, 256'd0,
        256'd9, 256'd0, 256'd0, 256'd0
    };

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_operand_sequencer #(
        .DATA(DATA),
        .ADDR(ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .ram_a_w    (ram_a_w),
        .ram_a_adbus(ram_a_adbus),
        .ram_a_wdata(ram_a_wdata),
        .ram_a_rdata(ram_a_rdata),
        .ram_b_w    (ram_b_w),
        .ram_b_adbus(ram_b_adbus),
        .ram_b_rdata(ram_b_rdata),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .done       (done),
        .busy       (busy)
    );

    // Dual-port RAM, registered reads, write through port A only.
    always @(posedge clk) begin
        if (ram_a_w) begin
            mem[ram_a_adbus] <= ram_a_wdata;
        end
        ram_a_rdata <= mem[ram_a_adbus];
        ram_b_rdata <= mem[ram_b_adbus];
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DATA-1:0] act,
                        input logic [DATA-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [ADDR-1:0] sa;
        logic [ADDR-1:0] sb;
        logic [ADDR-1:0] dst;
        int              rdly;
        int              vdly;
        bit              junk;
        logic [DATA-1:0] ea;
        logic [DATA-1:0] eb;
        logic [DATA-1:0] er;
        int              issue;
    } vec_t;

    vec_t tbl [4];

    // Runs one command from acceptance (T0) to completion, checking each cycle.
    task automatic run(input vec_t v);
        int              cyc;
        int              rcnt;
        int              vcnt;
        int              exp_done;
        bit              resph;
        bit              got;
        logic [DATA-1:0] prod;
        exp_done  = v.issue + v.rdly + v.vdly + 2;
        cmd_src_a = v.sa;
        cmd_src_b = v.sb;
        cmd_dst   = v.dst;
        cmd_valid = 1'b1;
        chk1("cmd_ready_T0", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        cyc   = 1;
        rcnt  = 0;
        vcnt  = 0;
        resph = 1'b0;
        got   = 1'b0;
        prod  = '0;
        while (!got && cyc < 60) begin
            op_ready  = op_valid && (rcnt >= v.rdly);
            res_valid = resph && (vcnt >= v.vdly);
            res_data  = prod;
            if (v.junk && op_valid && !op_ready) begin
                res_valid = 1'b1;
                res_data  = '1;
            end
            chk1("cmd_ready_busy", cmd_ready, 1'b0);
            chk1("busy", busy, 1'b1);
            chk1("ram_b_w", ram_b_w, 1'b0);
            chk1("res_ready", res_ready, resph);
            chk1("done_vs_write", done, ram_a_w);
            if (resph) begin
                if (res_valid) begin
                    resph = 1'b0;
                end
                vcnt++;
            end
            if (op_valid) begin
                if (rcnt == 0) begin
                    chki("issue_cycle", cyc, v.issue);
                end
                chkd("op_a", op_a, v.ea);
                chkd("op_b", op_b, v.eb);
                rcnt++;
                if (op_ready) begin
                    resph = 1'b1;
                    prod  = op_a * op_b;
                end
            end
            if (done) begin
                got = 1'b1;
                chki("done_cycle", cyc, exp_done);
                chki("wr_addr", int'(ram_a_adbus), int'(v.dst));
                chkd("wr_data", ram_a_wdata, v.er);
            end
            step();
            cyc++;
        end
        op_ready  = 1'b0;
        res_valid = 1'b0;
        chk1("done_seen", got, 1'b1);
        chk1("cmd_ready_after", cmd_ready, 1'b1);
        chk1("busy_after", busy, 1'b0);
        chkd("ram_dst", mem[v.dst], v.er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'd1, 3'd2, 3'd3, 0, 0, 1'b0,
                   256'd5, 256'd7, 256'd35, 3};
        tbl[1] = '{3'd1, 3'd2, 3'd3, 3, 4, 1'b1,
                   256'd5, 256'd7, 256'd35, 3};
`ifdef RAM_SEQ_FWD_EN
        tbl[2] = '{3'd3, 3'd3, 3'd5, 0, 0, 1'b0,
                   256'd35, 256'd35, 256'd1225, 1};
`else
        tbl[2] = '{3'd3, 3'd3, 3'd5, 0, 0, 1'b0,
                   256'd35, 256'd35, 256'd1225, 3};
`endif
        tbl[3] = '{3'd4, 3'd4, 3'd4, 0, 0, 1'b0,
                   256'd9, 256'd9, 256'd81, 3};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_src_a = '0;
        cmd_src_b = '0;
        cmd_dst   = '0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        step();
        step();
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_op_valid", op_valid, 1'b0);
        chk1("rst_res_ready", res_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ram_a_w", ram_a_w, 1'b0);
        chkd("rst_op_a", op_a, '0);
        chkd("rst_wdata", ram_a_wdata, '0);
        rst = 1'b0;
        step();
        chk1("idle_cmd_ready", cmd_ready, 1'b1);

        // Result offered while idle must be ignored.
        res_valid = 1'b1;
        res_data  = '1;
        for (int i = 0; i < 2; i++) begin
            chk1("idle_res_ready", res_ready, 1'b0);
            chk1("idle_done", done, 1'b0);
            chk1("idle_ram_a_w", ram_a_w, 1'b0);
            step();
        end
        res_valid = 1'b0;
        chk1("idle_still", busy, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run(tbl[i]);
        end

        // Reset while waiting for a result that is offered the same cycle.
        cmd_src_a = 3'd1;
        cmd_src_b = 3'd2;
        cmd_dst   = 3'd7;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int n = 0; n < 10 && !res_ready; n++) begin
            op_ready = op_valid;
            step();
        end
        op_ready = 1'b0;
        chk1("abort_in_wait", res_ready, 1'b1);
        res_valid = 1'b1;
        res_data  = 256'd123;
        rst       = 1'b1;
        step();
        chk1("abort_cmd_ready", cmd_ready, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_res_ready", res_ready, 1'b0);
        chk1("abort_ram_a_w", ram_a_w, 1'b0);
        chk1("abort_done", done, 1'b0);
        chki("abort_addr", int'(ram_a_adbus), 0);
        chkd("abort_op_a", op_a, '0);
        chkd("abort_op_b", op_b, '0);
        chkd("abort_wdata", ram_a_wdata, '0);
        rst       = 1'b0;
        res_valid = 1'b0;
        step();
        chk1("abort_idle", cmd_ready, 1'b1);
        step();
        chkd("abort_no_write", mem[7], '0);

        // Forwarding state must be cleared by reset: RAM path, issue at T3.
        run('{3'd4, 3'd4, 3'd6, 0, 0, 1'b0,
              256'd81, 256'd81, 256'd6561, 3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
